branch_target_loader: RTL and testbench



---
 rtl/btl_pkg.sv | 15 +
 rtl/btl_table.sv | 32 +++
 rtl/branch_target_loader.sv | 111 +++++++++++
 tb/tb_branch_target_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/btl_pkg.sv
// Shared types and constants for the branch-target loader and its table.
package btl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } btl_state_t;

  localparam int DEF_A       = 5;
  localparam int NUM_ENTRIES = 2**DEF_A;
  localparam int HOLD_IDX    = 0;

endpackage

// File: rtl/btl_table.sv
// Branch-target register file: one synchronous write port, one combinational
// read port, entry HOLD_IDX hardwired to zero.
module btl_table
  import btl_pkg::*;
#(
  parameter int D = 12,
  parameter int A = DEF_A
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [A-1:0] waddr,
  input  logic [D-1:0] wdata,
  input  logic [A-1:0] raddr,
  output logic [D-1:0] rdata
);

  localparam int N = 2**A;

  logic [D-1:0] mem [N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (we && waddr != A'(HOLD_IDX)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (raddr == A'(HOLD_IDX)) ? '0 : mem[raddr];

endmodule

// File: rtl/branch_target_loader.sv
// Loads (index, target) pairs into the branch-target table and serves fetch
// lookups. Define BTL_DUP_CHECK_EN to reject repeat writes to an index.
module branch_target_loader
  import btl_pkg::*;
#(
  parameter int D = 12,
  parameter int A = DEF_A
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         ld_valid,
  output logic         ld_ready,
  input  logic [A-1:0] ld_addr,
  input  logic [D-1:0] ld_target,
  input  logic         ld_last,
  input  logic [A-1:0] rd_addr,
  output logic [D-1:0] rd_target,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [A:0]   loaded_cnt
);

  localparam int         N       = 2**A;
  localparam logic [A:0] CNT_MAX = (A+1)'(N);

  btl_state_t   state, state_nxt;
  logic [A-1:0] clr_idx;
  logic         start_ok, hs, dup, wr_ok;
  logic         tab_we;
  logic [A-1:0] tab_waddr;
  logic [D-1:0] tab_wdata, tab_rdata;

  assign ld_ready = (state == LOAD);
  assign busy     = (state == CLEAR) || (state == LOAD);
  assign done     = (state == DONE);
  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign hs       = ld_valid && ld_ready;
  assign wr_ok    = hs && (ld_addr != A'(HOLD_IDX)) && !dup;

`ifdef BTL_DUP_CHECK_EN
  logic [N-1:0] written;

  // Bitmap is wiped alongside the table during CLEAR, one bit per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      written <= '0;
    end else if (state == CLEAR) begin
      written[clr_idx] <= 1'b0;
    end else if (wr_ok) begin
      written[ld_addr] <= 1'b1;
    end
  end

  assign dup = written[ld_addr];
`else
  assign dup = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   if (clr_idx == '1) state_nxt = LOAD;
      LOAD:    if (hs && ld_last) state_nxt = DONE;
      DONE:    if (start) state_nxt = CLEAR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_idx    <= '0;
      err        <= 1'b0;
      loaded_cnt <= '0;
    end else if (start_ok) begin
      clr_idx    <= '0;
      err        <= 1'b0;
      loaded_cnt <= '0;
    end else begin
      if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
      if (hs && !wr_ok) err <= 1'b1;
      if (wr_ok && loaded_cnt != CNT_MAX) loaded_cnt <= loaded_cnt + 1'b1;
    end
  end

  // CLEAR owns the write port; otherwise it carries accepted load entries.
  assign tab_we    = (state == CLEAR) || wr_ok;
  assign tab_waddr = (state == CLEAR) ? clr_idx : ld_addr;
  assign tab_wdata = (state == CLEAR) ? '0 : ld_target;

  btl_table #(.D(D), .A(A)) u_table (
    .clk   (clk),
    .reset (reset),
    .we    (tab_we),
    .waddr (tab_waddr),
    .wdata (tab_wdata),
    .raddr (rd_addr),
    .rdata (tab_rdata)
  );

  // Fetch only sees a settled table.
  assign rd_target = ((state == IDLE) || (state == DONE)) ? tab_rdata : '0;

endmodule

// File: tb/tb_branch_target_loader.sv
// Directed and randomized bench for branch_target_loader against a table model.
module tb_branch_target_loader;
  import btl_pkg::*;

  localparam int D = 12;
  localparam int A = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         ld_valid = 1'b0;
  logic         ld_ready;
  logic [A-1:0] ld_addr = '0;
  logic [D-1:0] ld_target = '0;
  logic         ld_last = 1'b0;
  logic [A-1:0] rd_addr = '0;
  logic [D-1:0] rd_target;
  logic         busy, done, err;
  logic [A:0]   loaded_cnt;

  int n_chk = 0;
  int n_fail = 0;

  int  exp_tab [NUM_ENTRIES];
  bit  exp_wr  [NUM_ENTRIES];
  bit  exp_err;
  int  exp_cnt;

  branch_target_loader #(.D(D), .A(A)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_target  (ld_target),
    .ld_last    (ld_last),
    .rd_addr    (rd_addr),
    .rd_target  (rd_target),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .loaded_cnt (loaded_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      exp_tab[i] = 0;
      exp_wr[i]  = 1'b0;
    end
    exp_err = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic model_accept(input int a, input int t);
    if (a == HOLD_IDX) begin
      exp_err = 1'b1;
    end else begin
`ifdef BTL_DUP_CHECK_EN
      if (exp_wr[a]) begin
        exp_err = 1'b1;
        return;
      end
`endif
      exp_tab[a] = t;
      exp_wr[a]  = 1'b1;
      if (exp_cnt < NUM_ENTRIES) exp_cnt++;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      rd_addr = A'(i);
      #1;
      chk({tag, "_rd"}, 32'(rd_target), exp_tab[i]);
    end
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_cnt"}, 32'(loaded_cnt), exp_cnt);
    tick();
  endtask

  task automatic do_start();
    rd_addr = A'($urandom_range(1, NUM_ENTRIES - 1));
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
    chk("start_busy", 32'(busy), 1);
    chk("start_err", 32'(err), 0);
    chk("start_cnt", 32'(loaded_cnt), 0);
  endtask

  // Exactly NUM_ENTRIES clear cycles; a start pulsed mid-clear must not restart it.
  task automatic wait_clear(input int pulse_at);
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      chk("clr_ready", 32'(ld_ready), 0);
      chk("clr_rd_gated", 32'(rd_target), 0);
      chk("clr_cnt", 32'(loaded_cnt), 0);
      start = (k == pulse_at);
      tick();
      start = 1'b0;
    end
    chk("load_ready", 32'(ld_ready), 1);
  endtask

  task automatic load(input int a, input int t, input bit last);
    int w = 0;
    ld_valid = 1'b1; ld_addr = A'(a); ld_target = D'(t); ld_last = last;
    while (ld_ready !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    if (ld_ready !== 1'b1) begin
      chk("ready_timeout", 32'(ld_ready), 1);
      ld_valid = 1'b0; ld_last = 1'b0;
      return;
    end
    if (last) chk("done_early", 32'(done), 0);
    tick();
    model_accept(a, t);
    ld_valid = 1'b0; ld_last = 1'b0;
    if (last) begin
      chk("last_done", 32'(done), 1);
      chk("last_ready", 32'(ld_ready), 0);
      chk("last_busy", 32'(busy), 0);
    end
  endtask

  initial begin
    model_clear();
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(ld_ready), 0);
    reset = 1'b0;
    tick();
    chk("idle_done", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_ready", 32'(ld_ready), 0);
    check_all("idle");

    // Basic load with ld_valid held high from start.
    ld_valid = 1'b1; ld_addr = 5'd1; ld_target = 12'd9;
    do_start();
    wait_clear(-1);
    load(1, 9, 1'b0);
    load(2, 15, 1'b0);
    load(3, 48, 1'b1);
    rd_addr = 5'd2; #1; chk("basic_rd2", 32'(rd_target), 15);
    rd_addr = 5'd4; #1; chk("basic_rd4", 32'(rd_target), 0);
    chk("basic_cnt", 32'(loaded_cnt), 3);
    check_all("basic");

    // ld_valid in DONE is ignored.
    for (int k = 0; k < 4; k++) begin
      ld_valid = 1'b1; ld_addr = 5'd6; ld_target = 12'd123;
      tick();
    end
    ld_valid = 1'b0;
    check_all("done_ignore");

    // Reserved index, with a start pulse during CLEAR that must be ignored.
    do_start();
    wait_clear(10);
    load(0, 77, 1'b0);
    load(5, 58, 1'b1);
    chk("rsv_err", 32'(err), 1);
    chk("rsv_cnt", 32'(loaded_cnt), 1);
    check_all("reserved");

    // Duplicate index.
    do_start();
    wait_clear(-1);
    load(7, 68, 1'b0);
    load(7, 99, 1'b1);
`ifdef BTL_DUP_CHECK_EN
    rd_addr = 5'd7; #1; chk("dup_rd7", 32'(rd_target), 68);
    chk("dup_err", 32'(err), 1);
    chk("dup_cnt", 32'(loaded_cnt), 1);
`else
    rd_addr = 5'd7; #1; chk("dup_rd7", 32'(rd_target), 99);
    chk("dup_err", 32'(err), 0);
    chk("dup_cnt", 32'(loaded_cnt), 2);
`endif
    check_all("dup");

    // Randomized rounds, the last long enough to reach counter saturation.
    for (int r = 0; r < 4; r++) begin
      int n;
      n = (r == 3) ? 40 : $urandom_range(1, 20);
      do_start();
      wait_clear(-1);
      for (int e = 0; e < n; e++) begin
        int a, t;
        a = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, NUM_ENTRIES - 1);
        t = $urandom_range(1, (1 << D) - 1);
        if ($urandom_range(0, 3) == 0) begin
          ld_valid = 1'b0;
          tick();
        end
        load(a, t, e == n - 1);
      end
      check_all("rand");
    end

    // Reload from DONE: old contents must be gone.
    do_start();
    wait_clear(-1);
    load(15, 17, 1'b1);
    rd_addr = 5'd15; #1; chk("reload_rd15", 32'(rd_target), 17);
    check_all("reload");

    // Asynchronous reset in the middle of LOAD.
    do_start();
    wait_clear(-1);
    load(4, 5, 1'b0);
    load(9, 11, 1'b0);
    rd_addr = 5'd4;
    #2 reset = 1'b1;
    #1;
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_ready", 32'(ld_ready), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_err", 32'(err), 0);
    chk("mrst_cnt", 32'(loaded_cnt), 0);
    chk("mrst_rd", 32'(rd_target), 0);
    tick();
    reset = 1'b0;
    model_clear();
    tick();
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_done", 32'(done), 0);
    check_all("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
